// File: rtl/counter8_pkg.sv
// ---------------------------------------------------------------------------
// counter8_pkg
//
// Shared definitions for the counter8 sequencing stage:
//   COUNT_WIDTH  - width of the count / load / target / next-value buses
//   COUNT_MAX    - all-ones count value, the top of the modulo range
//   state_t      - FSM states of the sequencer (IDLE, RUN, DONE)
//   atWrapBound  - true when a step in the given direction would cross the
//                  modulo boundary (FF->00 going up, 00->FF going down)
// ---------------------------------------------------------------------------
package counter8_pkg;

    localparam int COUNT_WIDTH = 8;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The sequencer never does arithmetic itself; it only needs to know
    // whether the current count sits on the edge of the range for the
    // direction it is stepping in.
    function automatic logic atWrapBound(input logic [COUNT_WIDTH-1:0] count,
                                         input logic                   isAdd);
        if (isAdd) begin
            return (count == COUNT_MAX);
        end
        return (count == '0);
    endfunction

endpackage

// File: rtl/counter8_seq.sv
// ---------------------------------------------------------------------------
// counter8_seq
//
// Sequencing / register stage sitting in front of the 8-bit add/sub counter
// datapath. It owns the architectural count, tells the datapath whether to
// add or subtract, takes the datapath's next value back, and walks a
// load / start / step-to-target sequence, flagging wrap and completion.
//
// Ports:
//   iClk      in   1   clock, all state changes on the rising edge
//   iRst      in   1   synchronous active-high reset
//   iLoad     in   1   load request (IDLE only, wins over iStart)
//   iLoadVal  in   W   value loaded into the count
//   iStart    in   1   start a counting run (IDLE only)
//   _iUpDown  in   1   direction captured at start, 1 = up (add)
//   iTarget   in   W   terminal value captured at start
//   iEn       in   1   step enable while running
//   iAbort    in   1   abandon the run, back to IDLE (wins over iEn)
//   iNext     in   W   datapath result for (oCount, oIsAdd)
//   oCount    out  W   registered count, feeds the datapath
//   oIsAdd    out  1   registered direction, feeds the datapath select
//   oBusy     out  1   high while running (decoded from state)
//   oDone     out  1   one-cycle pulse in the DONE cycle
//   oWrap     out  1   one-cycle pulse in the cycle showing a wrapped count
//
// Build option:
//   COUNTER8_SAT_EN - when defined, a step that would wrap is suppressed,
//                     the count holds and the run ends in DONE; oWrap is
//                     tied low. Undefined: plain modulo counting.
// ---------------------------------------------------------------------------
module counter8_seq
    import counter8_pkg::*;
#(
    parameter int CountWidth = COUNT_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iLoad,
    input  logic [CountWidth-1:0] iLoadVal,
    input  logic                  iStart,
    input  logic                  _iUpDown,
    input  logic [CountWidth-1:0] iTarget,
    input  logic                  iEn,
    input  logic                  iAbort,
    input  logic [CountWidth-1:0] iNext,
    output logic [CountWidth-1:0] oCount,
    output logic                  oIsAdd,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oWrap
);

    state_t                r_state;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth-1:0] r_target;
    logic                  r_isAdd;
    logic                  r_done;
`ifndef COUNTER8_SAT_EN
    logic                  r_wrap;
`endif

    logic                  w_atBound;
    logic                  w_hitTarget;

    // Boundary and target checks on the current step. The datapath result
    // is trusted as-is; the bound check only looks at where we are now and
    // which way we are going.
    assign w_atBound   = atWrapBound(r_count, r_isAdd);
    assign w_hitTarget = (iNext == r_target);

    // Main sequencer: state, count, captured direction/target and the
    // registered pulse outputs all update together. Pulses default low
    // every cycle so they can only ever last one cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_isAdd  <= 1'b1;
            r_done   <= 1'b0;
`ifndef COUNTER8_SAT_EN
            r_wrap   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifndef COUNTER8_SAT_EN
            r_wrap <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Load wins over start when both arrive together.
                    if (iLoad) begin
                        r_count <= iLoadVal;
                    end else if (iStart) begin
                        r_isAdd  <= _iUpDown;
                        r_target <= iTarget;
                        // Already sitting on the target: a zero-step run.
                        if (r_count == iTarget) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    // Abort wins over a step and never produces oDone.
                    if (iAbort) begin
                        r_state <= ST_IDLE;
                    end else if (iEn) begin
`ifdef COUNTER8_SAT_EN
                        // Saturating build: refuse the wrapping step and
                        // finish the run where we are.
                        if (w_atBound) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= iNext;
                            if (w_hitTarget) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
`else
                        r_count <= iNext;
                        r_wrap  <= w_atBound;
                        if (w_hitTarget) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oCount = r_count;
    assign oIsAdd = r_isAdd;
    assign oBusy  = (r_state == ST_RUN);
    assign oDone  = r_done;
`ifdef COUNTER8_SAT_EN
    assign oWrap  = 1'b0;
`else
    assign oWrap  = r_wrap;
`endif

endmodule

// File: tb/tb_counter8_seq.sv
// ---------------------------------------------------------------------------
// tb_counter8_seq
//
// Self-checking bench for counter8_seq. A table of directed vectors walks
// load, up/down runs, zero-step runs, simultaneous-event priorities, abort
// and reset-during-run; hand-written sequences then cover the wrap corners,
// whose expectations depend on COUNTER8_SAT_EN. The bench plays the role of
// the add/sub datapath, feeding back oCount +/- 1 on iNext.
// ---------------------------------------------------------------------------
module tb_counter8_seq;

    logic       iClk;
    logic       iRst;
    logic       iLoad;
    logic [7:0] iLoadVal;
    logic       iStart;
    logic       _iUpDown;
    logic [7:0] iTarget;
    logic       iEn;
    logic       iAbort;
    logic [7:0] iNext;
    logic [7:0] oCount;
    logic       oIsAdd;
    logic       oBusy;
    logic       oDone;
    logic       oWrap;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       load;
        logic [7:0] loadVal;
        logic       start;
        logic       up;
        logic [7:0] target;
        logic       en;
        logic       abort;
        logic [7:0] expCount;
        logic       expAdd;
        logic       expBusy;
        logic       expDone;
        logic       expWrap;
    } vec_t;

    localparam int NumVecs = 29;
    vec_t vecs [NumVecs];

    counter8_seq #(.CountWidth(8)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iLoad    (iLoad),
        .iLoadVal (iLoadVal),
        .iStart   (iStart),
        ._iUpDown (_iUpDown),
        .iTarget  (iTarget),
        .iEn      (iEn),
        .iAbort   (iAbort),
        .iNext    (iNext),
        .oCount   (oCount),
        .oIsAdd   (oIsAdd),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oWrap    (oWrap)
    );

    // Stand-in for the add/sub datapath downstream of the sequencer.
    assign iNext = oIsAdd ? (oCount + 8'd1) : (oCount - 8'd1);

    // Free-running 10-unit clock.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Drive one cycle of inputs, let the rising edge take them, and settle
    // 1 time unit past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic       rst,
                                 input logic       load,
                                 input logic [7:0] loadVal,
                                 input logic       start,
                                 input logic       up,
                                 input logic [7:0] target,
                                 input logic       en,
                                 input logic       abort);
        iRst     = rst;
        iLoad    = load;
        iLoadVal = loadVal;
        iStart   = start;
        _iUpDown = up;
        iTarget  = target;
        iEn      = en;
        iAbort   = abort;
        @(posedge iClk);
        #1;
    endtask

    // Compare all outputs against one expected tuple as a single check.
    task automatic checkOutput(input string      name,
                               input logic [7:0] expCount,
                               input logic       expAdd,
                               input logic       expBusy,
                               input logic       expDone,
                               input logic       expWrap);
        checkCount++;
        if (oCount === expCount && oIsAdd === expAdd && oBusy === expBusy &&
            oDone === expDone && oWrap === expWrap) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got cnt=%02h add=%b busy=%b done=%b wrap=%b, expected cnt=%02h add=%b busy=%b done=%b wrap=%b",
                     name, oCount, oIsAdd, oBusy, oDone, oWrap,
                     expCount, expAdd, expBusy, expDone, expWrap);
        end
    endtask

    // Directed vectors, applied back to back; each row's expectation is
    // the state of the outputs just after that row's clock edge.
    initial begin
        //          name           rst  ld   ldv    st   up   tgt    en   ab    cnt    add  busy done wrap
        vecs[0]  = '{"reset",      1'b1,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h00, 1'b1,1'b0,1'b0,1'b0};
        vecs[1]  = '{"load05",     1'b0,1'b1,8'h05, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h05, 1'b1,1'b0,1'b0,1'b0};
        vecs[2]  = '{"startUp08",  1'b0,1'b0,8'h00, 1'b1,1'b1,8'h08, 1'b0,1'b0, 8'h05, 1'b1,1'b1,1'b0,1'b0};
        vecs[3]  = '{"step06",     1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h06, 1'b1,1'b1,1'b0,1'b0};
        vecs[4]  = '{"step07",     1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h07, 1'b1,1'b1,1'b0,1'b0};
        vecs[5]  = '{"step08Done", 1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h08, 1'b1,1'b0,1'b1,1'b0};
        vecs[6]  = '{"doneToIdle", 1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h08, 1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{"idleIgnEn",  1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b1, 8'h08, 1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{"load03",     1'b0,1'b1,8'h03, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h03, 1'b1,1'b0,1'b0,1'b0};
        vecs[9]  = '{"startDn00",  1'b0,1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,1'b0, 8'h03, 1'b0,1'b1,1'b0,1'b0};
        vecs[10] = '{"dnStep02",   1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,1'b0, 8'h02, 1'b0,1'b1,1'b0,1'b0};
        vecs[11] = '{"holdLdFlip", 1'b0,1'b1,8'hAA, 1'b0,1'b1,8'h00, 1'b0,1'b0, 8'h02, 1'b0,1'b1,1'b0,1'b0};
        vecs[12] = '{"dnStep01",   1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h01, 1'b0,1'b1,1'b0,1'b0};
        vecs[13] = '{"holdIgnSt",  1'b0,1'b0,8'h00, 1'b1,1'b1,8'h01, 1'b0,1'b0, 8'h01, 1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{"dnStep00",   1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,1'b0, 8'h00, 1'b0,1'b0,1'b1,1'b0};
        vecs[15] = '{"dnIdle",     1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h00, 1'b0,1'b0,1'b0,1'b0};
        vecs[16] = '{"load10",     1'b0,1'b1,8'h10, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h10, 1'b0,1'b0,1'b0,1'b0};
        vecs[17] = '{"zeroStep",   1'b0,1'b0,8'h00, 1'b1,1'b1,8'h10, 1'b0,1'b0, 8'h10, 1'b1,1'b0,1'b1,1'b0};
        vecs[18] = '{"zeroIdle",   1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h10, 1'b1,1'b0,1'b0,1'b0};
        vecs[19] = '{"loadAndSt",  1'b0,1'b1,8'h22, 1'b1,1'b0,8'h30, 1'b0,1'b0, 8'h22, 1'b1,1'b0,1'b0,1'b0};
        vecs[20] = '{"stillIdle",  1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h22, 1'b1,1'b0,1'b0,1'b0};
        vecs[21] = '{"startUp30",  1'b0,1'b0,8'h00, 1'b1,1'b1,8'h30, 1'b0,1'b0, 8'h22, 1'b1,1'b1,1'b0,1'b0};
        vecs[22] = '{"step23",     1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b0, 8'h23, 1'b1,1'b1,1'b0,1'b0};
        vecs[23] = '{"abortAndEn", 1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b1,1'b1, 8'h23, 1'b1,1'b0,1'b0,1'b0};
        vecs[24] = '{"abortIdle",  1'b0,1'b0,8'h00, 1'b0,1'b1,8'h00, 1'b0,1'b0, 8'h23, 1'b1,1'b0,1'b0,1'b0};
        vecs[25] = '{"load37",     1'b0,1'b1,8'h37, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h37, 1'b1,1'b0,1'b0,1'b0};
        vecs[26] = '{"startDn",    1'b0,1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,1'b0, 8'h37, 1'b0,1'b1,1'b0,1'b0};
        vecs[27] = '{"rstInRun",   1'b1,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,1'b0, 8'h00, 1'b1,1'b0,1'b0,1'b0};
        vecs[28] = '{"afterRst",   1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0, 8'h00, 1'b1,1'b0,1'b0,1'b0};

        iRst = 1'b1; iLoad = 1'b0; iLoadVal = '0; iStart = 1'b0;
        _iUpDown = 1'b0; iTarget = '0; iEn = 1'b0; iAbort = 1'b0;
        @(posedge iClk);
        #1;

        for (int i = 0; i < NumVecs; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].loadVal,
                          vecs[i].start, vecs[i].up, vecs[i].target,
                          vecs[i].en, vecs[i].abort);
            checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expAdd,
                        vecs[i].expBusy, vecs[i].expDone, vecs[i].expWrap);
        end

        // Up run across FF->00 towards target 01.
        applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("wrapLoadFE", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        checkOutput("wrapStart", 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput("wrapToFF", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
`ifdef COUNTER8_SAT_EN
        checkOutput("satHoldFF", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        checkOutput("wrapTo00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
`ifdef COUNTER8_SAT_EN
        checkOutput("satIdle", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("wrapTo01Done", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef COUNTER8_SAT_EN
        checkOutput("satStayIdle", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("wrapIdle", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Down step 00->FF that also lands on the target in the same edge.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("dnLoad00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        checkOutput("dnStartFF", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef COUNTER8_SAT_EN
        checkOutput("dnSatHold", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        checkOutput("dnWrapDone", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef COUNTER8_SAT_EN
        checkOutput("dnSatIdle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("dnWrapIdle", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
